// File: rtl/campo_alarma_ctrl_if.sv
// rtl/campo_alarma_ctrl_if.sv - edit/alarm signal bundle between input logic, controller and pixel generator
interface campo_alarma_ctrl_if;
    logic [2:0] switch_w;
    logic       btn_der;
    logic       btn_izq;
    logic       frame_start;
    logic       alarm_match;
    logic       alarm_stop;
    logic [8:0] cam_co;
    logic       bit_alarma;
    logic       edit_activo;

    modport master (
        output switch_w, btn_der, btn_izq, frame_start, alarm_match, alarm_stop,
        input  cam_co, bit_alarma, edit_activo
    );

    modport slave (
        input  switch_w, btn_der, btn_izq, frame_start, alarm_match, alarm_stop,
        output cam_co, bit_alarma, edit_activo
    );
endinterface

// File: rtl/campo_alarma_ctrl.sv
// rtl/campo_alarma_ctrl.sv - edit cursor highlight and alarm sequencer; optional CURSOR_BLINK_EN
module campo_alarma_ctrl #(
    parameter int BLINK_FRAMES         = 30,
    parameter int ALARM_TIMEOUT_FRAMES = 3600
) (
    input  logic                reloj,
    input  logic                resetM,
    campo_alarma_ctrl_if.slave  bus
);

    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
        $error("BLINK_FRAMES out of range");
    end
    if (ALARM_TIMEOUT_FRAMES < 1 || ALARM_TIMEOUT_FRAMES > 65535) begin : g_bad_timeout
        $error("ALARM_TIMEOUT_FRAMES out of range");
    end

    localparam logic [15:0] TIMEOUT_LAST = 16'(ALARM_TIMEOUT_FRAMES - 1);

    typedef enum logic [1:0] {REPOSO, SONANDO, SILENCIO} state_t;

    state_t      state;
    logic [2:0]  sw_q;
    logic [1:0]  idx;
    logic [8:0]  pend;
    logic [15:0] tcnt;
    logic        grp_ok;
    logic [3:0]  base;
    logic        sw_chg;
    logic        stop_now;

    always_comb begin
        grp_ok = 1'b1;
        base   = 4'd0;
        case (bus.switch_w)
            3'b100:  base = 4'd8;
            3'b010:  base = 4'd5;
            3'b001:  base = 4'd2;
            default: grp_ok = 1'b0;
        endcase
    end

    assign sw_chg   = (bus.switch_w != sw_q);
    assign stop_now = bus.alarm_stop || bus.edit_activo ||
                      (bus.frame_start && (tcnt == TIMEOUT_LAST));

    // Cursor and pending highlight track inputs every cycle; cam_co only samples on frame pulses.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            sw_q            <= 3'b000;
            idx             <= 2'd0;
            pend            <= 9'd0;
            bus.edit_activo <= 1'b0;
        end else begin
            sw_q            <= bus.switch_w;
            bus.edit_activo <= grp_ok;
            pend            <= grp_ok ? (9'd1 << (base - {2'b00, idx})) : 9'd0;
            if (sw_chg)
                idx <= 2'd0;
            else if (grp_ok && bus.btn_der && !bus.btn_izq)
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            else if (grp_ok && bus.btn_izq && !bus.btn_der)
                idx <= (idx == 2'd0) ? 2'd2 : idx - 2'd1;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] bcnt;
    logic       blink_off;

    always_ff @(posedge reloj) begin
        if (resetM || !bus.edit_activo || sw_chg) begin
            bcnt      <= 8'd0;
            blink_off <= 1'b0;
        end else if (bus.frame_start) begin
            if (bcnt == BLINK_LAST) begin
                bcnt      <= 8'd0;
                blink_off <= ~blink_off;
            end else begin
                bcnt <= bcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge reloj) begin
        if (resetM)
            bus.cam_co <= 9'd0;
        else if (bus.frame_start)
            bus.cam_co <= blink_off ? 9'd0 : pend;
    end
`else
    always_ff @(posedge reloj) begin
        if (resetM)
            bus.cam_co <= 9'd0;
        else if (bus.frame_start)
            bus.cam_co <= pend;
    end
`endif

    // bit_alarma rises the cycle after entering SONANDO but drops on the same edge that leaves it.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            state          <= REPOSO;
            tcnt           <= 16'd0;
            bus.bit_alarma <= 1'b0;
        end else begin
            case (state)
                REPOSO: begin
                    bus.bit_alarma <= 1'b0;
                    if (bus.alarm_match && !bus.edit_activo) begin
                        state <= SONANDO;
                        tcnt  <= 16'd0;
                    end
                end
                SONANDO: begin
                    if (stop_now) begin
                        state          <= SILENCIO;
                        bus.bit_alarma <= 1'b0;
                    end else begin
                        bus.bit_alarma <= 1'b1;
                        if (bus.frame_start)
                            tcnt <= tcnt + 16'd1;
                    end
                end
                SILENCIO: begin
                    bus.bit_alarma <= 1'b0;
                    if (!bus.alarm_match)
                        state <= REPOSO;
                end
                default: begin
                    state          <= REPOSO;
                    bus.bit_alarma <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_campo_alarma_ctrl.sv
// tb/tb_campo_alarma_ctrl.sv - directed scoreboard bench for campo_alarma_ctrl
module tb_campo_alarma_ctrl;
    localparam int BF = 2;
    localparam int TO = 4;

    localparam logic [10:0] M_ALL = 11'h7FF;
    localparam logic [10:0] M_CAM = 11'h7FC;
    localparam logic [10:0] M_AL  = 11'b00000000010;
    localparam logic [10:0] M_ED  = 11'b00000000001;

    logic reloj = 1'b0;
    logic resetM;

    campo_alarma_ctrl_if bus ();

    campo_alarma_ctrl #(.BLINK_FRAMES(BF), .ALARM_TIMEOUT_FRAMES(TO)) dut (
        .reloj  (reloj),
        .resetM (resetM),
        .bus    (bus)
    );

    always #5 reloj = ~reloj;

    typedef struct {
        string       tag;
        logic [10:0] val;
        logic [10:0] mask;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   fr_cnt = 0;

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [10:0] val, input logic [10:0] mask);
        exp_t e;
        e.tag  = tag;
        e.val  = val;
        e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [10:0] obs;
        n_chk++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e   = sb.pop_front();
            obs = {bus.cam_co, bus.bit_alarma, bus.edit_activo};
            assert ((obs & e.mask) === (e.val & e.mask)) n_pass++;
            else $error("FAIL %s observed=%b expected=%b", e.tag, obs & e.mask, e.val & e.mask);
        end
    endtask

    task automatic frame(input string tag, input logic [8:0] hl, input logic edit_exp);
        logic [8:0] exp_cam;
        exp_cam = hl;
`ifdef CURSOR_BLINK_EN
        if (edit_exp && (((fr_cnt / BF) % 2) == 1))
            exp_cam = 9'd0;
`endif
        expect_val(tag, {exp_cam, 1'b0, edit_exp}, M_CAM | M_ED);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check();
        if (edit_exp)
            fr_cnt++;
        tick();
    endtask

    task automatic frame_pulse();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
    endtask

    task automatic buttons(input logic d, input logic i);
        bus.btn_der = d;
        bus.btn_izq = i;
        tick();
        bus.btn_der = 1'b0;
        bus.btn_izq = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        resetM           = 1'b1;
        bus.switch_w     = 3'b000;
        bus.btn_der      = 1'b0;
        bus.btn_izq      = 1'b0;
        bus.frame_start  = 1'b0;
        bus.alarm_match  = 1'b0;
        bus.alarm_stop   = 1'b0;

        expect_val("reset_state", 11'd0, M_ALL);
        tick();
        tick();
        check();

        resetM       = 1'b0;
        bus.switch_w = 3'b010;
        fr_cnt       = 0;
        tick(); tick(); tick();
        frame("time_first", 9'b000100000, 1'b1);

        buttons(1'b1, 1'b0);
        frame("der_idx1", 9'b000010000, 1'b1);
        buttons(1'b1, 1'b0);
        frame("der_idx2", 9'b000001000, 1'b1);
        buttons(1'b1, 1'b0);
        frame("der_wrap", 9'b000100000, 1'b1);
        buttons(1'b0, 1'b1);
        frame("izq_wrap", 9'b000001000, 1'b1);
        buttons(1'b1, 1'b1);
        frame("both_btn", 9'b000001000, 1'b1);

        expect_val("no_frame_hold", {9'b000001000, 2'b00}, M_CAM);
        buttons(1'b1, 1'b0);
        check();

        bus.switch_w = 3'b110;
        fr_cnt       = 0;
        tick(); tick();
        frame("illegal_sw", 9'd0, 1'b0);
        buttons(1'b1, 1'b0);
        frame("illegal_btn", 9'd0, 1'b0);

        bus.switch_w = 3'b100;
        fr_cnt       = 0;
        tick(); tick(); tick();
        for (int k = 0; k < 8; k++)
            frame($sformatf("date_frame%0d", k), 9'b100000000, 1'b1);
        frame("date_frame8", 9'b100000000, 1'b1);

        resetM = 1'b1;
        expect_val("reset_mid_edit", 11'd0, M_ALL);
        tick();
        check();
        resetM       = 1'b0;
        bus.switch_w = 3'b000;
        tick(); tick();

        bus.alarm_match = 1'b1;
        expect_val("alarm_ring", 11'b10, M_AL);
        tick(); tick();
        check();

        bus.alarm_stop = 1'b1;
        expect_val("alarm_stop", 11'b00, M_AL);
        tick();
        bus.alarm_stop = 1'b0;
        check();
        expect_val("alarm_stay_quiet", 11'b00, M_AL);
        tick(); tick(); tick();
        check();

        bus.alarm_match = 1'b0;
        tick(); tick();
        bus.alarm_match = 1'b1;
        expect_val("alarm_rering", 11'b10, M_AL);
        tick(); tick();
        check();

        frame_pulse(); frame_pulse(); frame_pulse();
        expect_val("timeout_pre", 11'b10, M_AL);
        check();
        expect_val("timeout_fire", 11'b00, M_AL);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check();

        bus.alarm_match = 1'b0;
        tick(); tick();
        bus.alarm_match = 1'b1;
        expect_val("ring_before_edit", 11'b10, M_AL);
        tick(); tick();
        check();
        bus.switch_w = 3'b001;
        expect_val("edit_kills_alarm", 11'b01, M_AL | M_ED);
        tick(); tick();
        check();

        bus.switch_w    = 3'b000;
        tick(); tick();
        bus.alarm_match = 1'b0;
        tick(); tick();
        bus.alarm_match = 1'b1;
        expect_val("ring_before_reset", 11'b10, M_AL);
        tick(); tick();
        check();
        resetM = 1'b1;
        expect_val("reset_mid_ring", 11'd0, M_ALL);
        tick();
        check();
        resetM = 1'b0;
        expect_val("ring_after_reset", 11'b10, M_AL);
        tick(); tick();
        check();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
